// File: rtl/fu_branch_resolve.sv
// Branch functional unit: resolves conditional branches and JALR, checks the
// fetch prediction, and buffers results in an in-order valid/ready queue.
module fu_branch_resolve #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int TAG_W  = 4,
   parameter int DEPTH  = 4
) (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [1:0]                 in_branch_type,
   input  logic                       in_gate_sel,
   input  logic [DATA_W-1:0]          in_reg_a,
   input  logic [DATA_W-1:0]          in_reg_b,
   input  logic [DATA_W-1:0]          in_imm,
   input  logic [ADDR_W-1:0]          in_pc,
   input  logic                       in_pred_taken,
   input  logic [ADDR_W-1:0]          in_pred_target,
   input  logic [TAG_W-1:0]           in_tag,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [TAG_W-1:0]           out_tag,
   output logic                       out_taken,
   output logic [ADDR_W-1:0]          out_target,
   output logic [ADDR_W-1:0]          out_correct_pc,
   output logic [DATA_W-1:0]          out_link,
   output logic                       out_mispredict,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      BR_EQ   = 2'd0,
      BR_LT   = 2'd1,
      BR_LTU  = 2'd2,
      BR_JALR = 2'd3
   } br_type_e;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic              taken;
      logic [ADDR_W-1:0] target;
      logic [ADDR_W-1:0] correct_pc;
      logic [DATA_W-1:0] link;
      logic              mispredict;
   } entry_t;

   entry_t            mem_q [DEPTH];
   entry_t            mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   entry_t            res;
   br_type_e          br_type;
   logic              eq, slt, ult;
   logic [ADDR_W-1:0] pc_plus4;
   logic [DATA_W-1:0] jalr_sum;
   logic              push, pop;

   // Resolution datapath
   always_comb begin
      br_type  = br_type_e'(in_branch_type);
      eq       = (in_reg_a == in_reg_b);
      slt      = ($signed(in_reg_a) < $signed(in_reg_b));
      ult      = (in_reg_a < in_reg_b);
      pc_plus4 = in_pc + ADDR_W'(4);
      jalr_sum = in_reg_a + in_imm;

      res        = '0;
      res.tag    = in_tag;
      res.target = in_pc + in_imm[ADDR_W-1:0];
      unique case (br_type)
         BR_EQ:   res.taken = eq ^ in_gate_sel;
         BR_LT:   res.taken = in_gate_sel ? slt : !slt;
         BR_LTU:  res.taken = in_gate_sel ? ult : !ult;
         BR_JALR: begin
            res.taken  = 1'b1;
            res.target = {jalr_sum[ADDR_W-1:1], 1'b0};
            res.link   = DATA_W'(pc_plus4);
         end
         default: res.taken = 1'b0;
      endcase
      res.correct_pc = res.taken ? res.target : pc_plus4;
      res.mispredict = (res.taken != in_pred_taken) ||
                       (res.taken && (res.target != in_pred_target));
   end

   // Flush forces in_ready high but suppresses the push it would allow
   always_comb begin
      out_valid = (count_q != '0);
      pop       = out_valid && out_ready;
      in_ready  = flush || (count_q < DEPTH_C) || pop;
      push      = in_valid && in_ready && !flush;

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = res;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Head fields read as zero whenever the queue is empty
   always_comb begin
      entry_t head;
      head           = out_valid ? mem_q[rd_ptr_q] : '0;
      out_tag        = head.tag;
      out_taken      = head.taken;
      out_target     = head.target;
      out_correct_pc = head.correct_pc;
      out_link       = head.link;
      out_mispredict = head.mispredict;
      count          = count_q;
   end

endmodule

// File: tb/tb_fu_branch_resolve.sv
// Directed self-checking bench for fu_branch_resolve: vector table for the
// resolution datapath plus hand-written queue, flush and reset sequences.
module tb_fu_branch_resolve;

   logic        clk;
   logic        nrst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_branch_type;
   logic        in_gate_sel;
   logic [31:0] in_reg_a, in_reg_b, in_imm, in_pc, in_pred_target;
   logic        in_pred_taken;
   logic [3:0]  in_tag;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_tag;
   logic        out_taken;
   logic [31:0] out_target, out_correct_pc, out_link;
   logic        out_mispredict;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   fu_branch_resolve #(.DATA_W(32), .ADDR_W(32), .TAG_W(4), .DEPTH(4)) dut (
      .CLK(clk), .nRST(nrst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_branch_type(in_branch_type), .in_gate_sel(in_gate_sel),
      .in_reg_a(in_reg_a), .in_reg_b(in_reg_b), .in_imm(in_imm), .in_pc(in_pc),
      .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
      .in_tag(in_tag), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
      .out_taken(out_taken), .out_target(out_target),
      .out_correct_pc(out_correct_pc), .out_link(out_link),
      .out_mispredict(out_mispredict), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  bt;
      logic        sel;
      logic [31:0] a, b, imm, pc;
      logic        pt;
      logic [31:0] ptgt;
      logic        taken;
      logic [31:0] tgt, cpc, link;
      logic        mis;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      vecs[0] = '{2'd0, 1'b0, 32'd10, 32'd10, 32'd100, 32'h0, 1'b0, 32'h0,
                  1'b1, 32'd100, 32'd100, 32'h0, 1'b1};
      vecs[1] = '{2'd0, 1'b1, 32'd10, 32'd10, 32'd100, 32'h0, 1'b0, 32'h0,
                  1'b0, 32'd100, 32'd4, 32'h0, 1'b0};
      vecs[2] = '{2'd2, 1'b1, 32'd8, 32'h80000000, 32'h10, 32'h40, 1'b1, 32'h50,
                  1'b1, 32'h50, 32'h50, 32'h0, 1'b0};
      vecs[3] = '{2'd1, 1'b1, 32'd8, 32'h80000000, 32'h10, 32'h40, 1'b1, 32'h50,
                  1'b0, 32'h50, 32'h44, 32'h0, 1'b1};
      vecs[4] = '{2'd2, 1'b0, 32'hFFFFFFFF, 32'd10, 32'hFFFFFFF8, 32'h100, 1'b0, 32'h0,
                  1'b1, 32'hF8, 32'hF8, 32'h0, 1'b1};
      vecs[5] = '{2'd3, 1'b0, 32'h1001, 32'h0, 32'd4, 32'h200, 1'b1, 32'h1004,
                  1'b1, 32'h1004, 32'h1004, 32'h204, 1'b0};
      vecs[6] = '{2'd3, 1'b1, 32'h1001, 32'h0, 32'd4, 32'h200, 1'b1, 32'h1000,
                  1'b1, 32'h1004, 32'h1004, 32'h204, 1'b1};
      vecs[7] = '{2'd0, 1'b0, 32'd5, 32'd5, 32'h20, 32'hFFFFFFF0, 1'b1, 32'h10,
                  1'b1, 32'h10, 32'h10, 32'h0, 1'b0};
      vecs[8] = '{2'd1, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd8, 32'h300, 1'b0, 32'hDEAD,
                  1'b0, 32'h308, 32'h304, 32'h0, 1'b0};
      vecs[9] = '{2'd0, 1'b1, 32'd1, 32'd2, 32'h20, 32'h10, 1'b1, 32'h34,
                  1'b1, 32'h30, 32'h30, 32'h0, 1'b1};

      nrst = 1'b0; in_valid = 1'b0; in_branch_type = 2'd0; in_gate_sel = 1'b0;
      in_reg_a = '0; in_reg_b = '0; in_imm = '0; in_pc = '0;
      in_pred_taken = 1'b0; in_pred_target = '0; in_tag = '0;
      flush = 1'b0; out_ready = 1'b1;

      #2;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_out_target", 64'(out_target), 64'd0);
      @(negedge clk); nrst = 1'b1;
      #1 check("rst_in_ready", 64'(in_ready), 64'd1);

      // Vector table: one request, checked the cycle after acceptance
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_tag = 4'(i);
         in_branch_type = vecs[i].bt; in_gate_sel = vecs[i].sel;
         in_reg_a = vecs[i].a; in_reg_b = vecs[i].b; in_imm = vecs[i].imm;
         in_pc = vecs[i].pc; in_pred_taken = vecs[i].pt; in_pred_target = vecs[i].ptgt;
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         check($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
         check($sformatf("v%0d_count", i), 64'(count), 64'd1);
         check($sformatf("v%0d_tag", i), 64'(out_tag), 64'(i));
         check($sformatf("v%0d_taken", i), 64'(out_taken), 64'(vecs[i].taken));
         check($sformatf("v%0d_target", i), 64'(out_target), 64'(vecs[i].tgt));
         check($sformatf("v%0d_cpc", i), 64'(out_correct_pc), 64'(vecs[i].cpc));
         check($sformatf("v%0d_link", i), 64'(out_link), 64'(vecs[i].link));
         check($sformatf("v%0d_mis", i), 64'(out_mispredict), 64'(vecs[i].mis));
      end
      @(negedge clk);
      #1 check("tbl_drained", 64'(count), 64'd0);

      // Fill to DEPTH with consumer stalled, then push+pop while full
      out_ready = 1'b0;
      in_branch_type = 2'd0; in_gate_sel = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); in_valid = 1'b1; in_tag = 4'(i);
      end
      @(negedge clk); in_tag = 4'd4;
      #1;
      check("full_count", 64'(count), 64'd4);
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("full_head_tag", 64'(out_tag), 64'd0);
      @(negedge clk);
      #1;
      check("full_hold_count", 64'(count), 64'd4);
      check("full_hold_tag", 64'(out_tag), 64'd0);
      out_ready = 1'b1;
      #1 check("full_pop_in_ready", 64'(in_ready), 64'd1);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("drain_tag%0d", k), 64'(out_tag), 64'(k));
         check($sformatf("drain_count%0d", k), 64'(count), 64'd4);
         @(negedge clk);
         in_tag = 4'(5 + k);
         #1;
      end
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check("empty_count", 64'(count), 64'd0);
      check("empty_valid", 64'(out_valid), 64'd0);

      // Flush with three queued entries and a same-cycle request
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); in_valid = 1'b1; in_tag = 4'(10 + i);
      end
      @(negedge clk); in_valid = 1'b0;
      #1;
      check("pre_flush_count", 64'(count), 64'd3);
      check("pre_flush_tag", 64'(out_tag), 64'd10);
      flush = 1'b1; in_valid = 1'b1; in_tag = 4'd13; out_ready = 1'b1;
      #1 check("flush_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk); flush = 1'b0; in_valid = 1'b0;
      #1;
      check("flush_count", 64'(count), 64'd0);
      check("flush_valid", 64'(out_valid), 64'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("post_flush_valid%0d", k), 64'(out_valid), 64'd0);
         check($sformatf("post_flush_tag13_%0d", k), 64'(out_tag == 4'd13), 64'd0);
      end

      // Asynchronous reset in the middle of a stream
      out_ready = 1'b0;
      for (int i = 1; i < 3; i++) begin
         @(negedge clk); in_valid = 1'b1; in_tag = 4'(i);
      end
      @(negedge clk); in_valid = 1'b0;
      #1 check("pre_rst_count", 64'(count), 64'd2);
      #2 nrst = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_count", 64'(count), 64'd0);
      check("mid_rst_tag", 64'(out_tag), 64'd0);
      @(negedge clk); nrst = 1'b1; out_ready = 1'b1;
      #1 check("post_rst_in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1; in_tag = 4'd7;
      @(negedge clk); in_valid = 1'b0;
      #1;
      check("post_rst_tag", 64'(out_tag), 64'd7);
      check("post_rst_count", 64'(count), 64'd1);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
